// File: rtl/xif_mem_responder_pkg.sv
// Shared types for the accelerator memory-channel responder: access size and request type.
package xif_mem_responder_pkg;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } mem_size_e;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } mem_req_type_e;

endpackage

// File: rtl/xif_mem_responder_if.sv
// Bundle of the cmem request/response channel, the LSU busy hint and the OBI data bus.
interface xif_mem_responder_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   import xif_mem_responder_pkg::*;

   logic                  cmem_q_valid_i;
   logic                  cmem_q_ready_o;
   logic [ADDR_WIDTH-1:0] cmem_q_addr_i;
   logic [DATA_WIDTH-1:0] cmem_q_wdata_i;
   mem_size_e             cmem_q_size_i;
   mem_req_type_e         cmem_q_req_type_i;
   logic                  cmem_q_mode_i;
   logic                  cmem_q_spec_i;
   logic                  cmem_q_endoftransaction_i;

   logic                  cmem_p_valid_o;
   logic                  cmem_p_ready_i;
   logic [DATA_WIDTH-1:0] cmem_p_rdata_o;
   logic                  cmem_p_status_o;

   logic                  lsu_busy_i;

   logic                  data_req_o;
   logic                  data_gnt_i;
   logic [ADDR_WIDTH-1:0] data_addr_o;
   logic                  data_we_o;
   logic [3:0]            data_be_o;
   logic [DATA_WIDTH-1:0] data_wdata_o;
   logic                  data_rvalid_i;
   logic [DATA_WIDTH-1:0] data_rdata_i;
   logic                  data_err_i;

   modport slave (
      input  cmem_q_valid_i, cmem_q_addr_i, cmem_q_wdata_i, cmem_q_size_i, cmem_q_req_type_i,
             cmem_q_mode_i, cmem_q_spec_i, cmem_q_endoftransaction_i, cmem_p_ready_i, lsu_busy_i,
             data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
      output cmem_q_ready_o, cmem_p_valid_o, cmem_p_rdata_o, cmem_p_status_o,
             data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o
   );

   modport master (
      output cmem_q_valid_i, cmem_q_addr_i, cmem_q_wdata_i, cmem_q_size_i, cmem_q_req_type_i,
             cmem_q_mode_i, cmem_q_spec_i, cmem_q_endoftransaction_i, cmem_p_ready_i, lsu_busy_i,
             data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
      input  cmem_q_ready_o, cmem_p_valid_o, cmem_p_rdata_o, cmem_p_status_o,
             data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o
   );

endinterface

// File: rtl/xif_mem_responder_lane_align.sv
// Byte-lane steering between an LSB-aligned cmem access and the 32-bit data bus.
module xif_mem_lane_align
   import xif_mem_responder_pkg::*;
(
   input  logic [1:0]  addr_off_i,
   input  mem_size_e   size_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        misaligned_o
);

   logic [31:0] rdata_shifted;

   // Store data is replicated so every lane the byte enables may select carries it.
   always_comb begin
      rdata_shifted = rdata_i >> {addr_off_i, 3'b000};
      case (size_i)
         BYTE: begin
            be_o         = 4'b0001 << addr_off_i;
            wdata_o      = {4{wdata_i[7:0]}};
            rdata_o      = {24'h0, rdata_shifted[7:0]};
            misaligned_o = 1'b0;
         end
         HALF: begin
            be_o         = 4'b0011 << addr_off_i;
            wdata_o      = {2{wdata_i[15:0]}};
            rdata_o      = {16'h0, rdata_shifted[15:0]};
            misaligned_o = addr_off_i[0];
         end
         default: begin
            be_o         = 4'b1111;
            wdata_o      = wdata_i;
            rdata_o      = rdata_shifted;
            misaligned_o = |addr_off_i;
         end
      endcase
   end

endmodule

// File: rtl/xif_mem_responder.sv
// Core-side cmem responder: one offloaded load/store at a time, turned into a single OBI transaction.
//
//   state | meaning
//   IDLE  | ready for a cmem request
//   REQ   | waiting for LSU to free the bus, then holding data_req_o until grant
//   WAIT  | granted, waiting for data_rvalid_i
//   RESP  | presenting cmem response until accepted
module xif_mem_responder
   import xif_mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic                clk_i,
   input logic                rst_ni,
   xif_mem_responder_if.slave bus_if
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   mem_size_e             size_q, size_d;
   mem_req_type_e         type_q, type_d;
   logic                  status_q, status_d;
   logic                  req_q, req_d;

   logic [1:0]  lane_off;
   mem_size_e   lane_size;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic [31:0] lane_rdata;
   logic        misaligned;
   logic        reject;

   // In IDLE the aligner looks at the incoming request so misalignment is known at handshake.
   always_comb begin
      lane_off  = addr_q[1:0];
      lane_size = size_q;
      if (state_q == IDLE) begin
         lane_off  = bus_if.cmem_q_addr_i[1:0];
         lane_size = bus_if.cmem_q_size_i;
      end
   end

   xif_mem_lane_align u_lane_align (
      .addr_off_i   (lane_off),
      .size_i       (lane_size),
      .wdata_i      (wdata_q),
      .rdata_i      (bus_if.data_rdata_i),
      .be_o         (lane_be),
      .wdata_o      (lane_wdata),
      .rdata_o      (lane_rdata),
      .misaligned_o (misaligned)
   );

   assign reject = misaligned | bus_if.cmem_q_mode_i | bus_if.cmem_q_spec_i |
                   ~bus_if.cmem_q_endoftransaction_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus_if.cmem_q_valid_i) state_d = reject ? RESP : REQ;
         REQ:  if (req_q && bus_if.data_gnt_i) state_d = WAIT;
         WAIT: if (bus_if.data_rvalid_i) state_d = RESP;
         RESP: if (bus_if.cmem_p_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      size_d   = size_q;
      type_d   = type_q;
      rdata_d  = rdata_q;
      status_d = status_q;
      req_d    = req_q;
      case (state_q)
         IDLE: begin
            if (bus_if.cmem_q_valid_i) begin
               addr_d   = bus_if.cmem_q_addr_i;
               wdata_d  = bus_if.cmem_q_wdata_i;
               size_d   = bus_if.cmem_q_size_i;
               type_d   = bus_if.cmem_q_req_type_i;
               rdata_d  = '0;
               status_d = reject;
               req_d    = ~reject & ~bus_if.lsu_busy_i;
            end
         end
         // Once raised, the request is held until granted regardless of lsu_busy_i.
         REQ: req_d = req_q ? ~bus_if.data_gnt_i : ~bus_if.lsu_busy_i;
         WAIT: begin
            if (bus_if.data_rvalid_i) begin
               rdata_d  = (type_q == READ) ? lane_rdata : '0;
               status_d = bus_if.data_err_i;
            end
         end
         RESP: begin
            if (bus_if.cmem_p_ready_i) begin
               rdata_d  = '0;
               status_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         size_q   <= BYTE;
         type_q   <= READ;
         rdata_q  <= '0;
         status_q <= 1'b0;
         req_q    <= 1'b0;
      end else begin
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         size_q   <= size_d;
         type_q   <= type_d;
         rdata_q  <= rdata_d;
         status_q <= status_d;
         req_q    <= req_d;
      end
   end

   always_comb begin
      bus_if.cmem_q_ready_o  = (state_q == IDLE);
      bus_if.cmem_p_valid_o  = (state_q == RESP);
      bus_if.cmem_p_rdata_o  = rdata_q;
      bus_if.cmem_p_status_o = status_q;
      bus_if.data_req_o      = req_q;
      bus_if.data_addr_o     = '0;
      bus_if.data_we_o       = 1'b0;
      bus_if.data_be_o       = 4'b0000;
      bus_if.data_wdata_o    = '0;
      if (req_q) begin
         bus_if.data_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
         bus_if.data_we_o    = (type_q == WRITE);
         bus_if.data_be_o    = lane_be;
         bus_if.data_wdata_o = lane_wdata;
      end
   end

endmodule
